sram_multiport_ctrl: RTL and testbench
======================================

# sram_multiport_ctrl

Parametrised external-SRAM controller serving NUM_CH independent request channels over a single asynchronous 16-bit SRAM (CE/UB/LB/OE/WE, active-low). Requests are accepted by per-channel req/gnt handshake, arbitrated round-robin and executed as fixed-length SETUP/ACCESS/HOLD bus cycles with programmable access length and byte enables. It replaces the fixed write/read alternating controller and sits between the rasterizer's memory clients (framebuffer writer, texture/depth readers, display scan-out) and the SRAM pins.

## Interface
Parameters:
- NUM_CH, 4, number of request channels (2..8)
- ADDR_W, 20, SRAM word-address width
- WAIT_CYCLES, 2, ACCESS-phase length in clocks (>= 1)

Ports:
- Clk_100  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req  input  NUM_CH  per-channel request, held until gnt
- we  input  NUM_CH  per-channel 1 = write, 0 = read
- addr  input  NUM_CH*ADDR_W  per-channel word address, channel i at bits [i*ADDR_W +: ADDR_W]
- wdata  input  NUM_CH*16  per-channel write data
- be  input  NUM_CH*2  per-channel byte enables, bit1 = upper byte, bit0 = lower byte
- gnt  output  NUM_CH  one-hot, one-cycle pulse: request accepted
- rd_valid  output  NUM_CH  one-hot, one-cycle pulse: rd_data valid for that channel
- rd_data  output  16  read data, shared by all channels
- busy  output  1  high whenever state is not IDLE
- CE, UB, LB, OE, WE  output  1 each  SRAM controls, active-low
- ADDR  output  ADDR_W  SRAM address
- Data  inout  16  SRAM data bus

## Operation
- States: IDLE, SETUP, ACCESS, HOLD.
- IDLE: if any req, pick winner = first requesting channel at or after rr_ptr (wrapping); pulse gnt[winner]; latch we/addr/wdata/be of winner; rr_ptr <= winner+1 mod NUM_CH; go SETUP. No req: stay IDLE.
- SETUP (1 cycle): CE=0, ADDR=latched addr, UB=~be[1], LB=~be[0], OE=WE=1; write: drive Data=wdata.
- ACCESS (WAIT_CYCLES cycles, down-counter): write: WE=0, Data driven; read: OE=0, Data released; read data captured into rd_data on the clock edge ending the last ACCESS cycle.
- HOLD (1 cycle): OE=WE=1, CE/ADDR/UB/LB still asserted; write: Data still driven (hold time); read: Data released, rd_valid[owner]=1. Then IDLE.
- All SRAM outputs, gnt, rd_valid, rd_data registered. Data driven only in SETUP/ACCESS/HOLD of a write; high-Z otherwise.
- be=2'b00: bus cycle still executed with UB=LB=1 (no byte affected); read still returns rd_valid with bus contents.
- Channel may change its inputs only after the gnt cycle; keeping req high after gnt is a new request.

## Timing
- Reset (async, immediate): CE=UB=LB=OE=WE=1, ADDR=0, Data high-Z, gnt=0, rd_valid=0, rd_data=0, busy=0, state IDLE, rr_ptr=0, counter 0.
- Reset mid-operation: in-flight access dropped, no rd_valid issued, bus released within the same cycle.
- Op started by gnt in cycle T: SETUP T+1, ACCESS T+2..T+WAIT_CYCLES+1, HOLD T+WAIT_CYCLES+2, next gnt earliest T+WAIT_CYCLES+3.
- Read latency req-accepted to rd_valid: WAIT_CYCLES+2 clocks; throughput one op per WAIT_CYCLES+3 clocks.
- Read->write turnaround: write SETUP is at least 2 cycles after read OE deasserts (HOLD + IDLE); no bus contention.
- Simultaneous requests: served strictly round-robin; with all NUM_CH requesting, each channel granted once per NUM_CH ops.
- rr_ptr wraps NUM_CH-1 -> 0.

## Test plan
- Reset: assert reset_n=0 mid-write (ACCESS) -> all controls 1, Data high-Z same cycle, no rd_valid; after release, IDLE, busy=0.
- Single write then read, WAIT_CYCLES=2: ch0 write addr 2 data 16'h000A be 2'b11 -> gnt T, WE=0 for T+2..T+3, Data=000A T+1..T+4; ch0 read addr 2 with SRAM model -> rd_valid[0] at T'+4, rd_data=000A.
- Byte enables: write be 2'b01 data 16'hABCD over 16'h1234 -> UB=1, LB=0; readback 16'h12CD.
- Round-robin: all 4 channels hold req continuously -> grant order 0,1,2,3,0,1 every 5 cycles; after only ch2,ch3 request with rr_ptr=3 -> order 3,2.
- Back-to-back read/write same channel, alternating, 16 ops on addresses 3..18 -> never Data driven while OE=0; all reads match prior writes.
- WAIT_CYCLES=1 and NUM_CH=2 build: read latency 3, op period 4, rr wraps 1->0.

Source files
------------

// File: rtl/sram_multiport_ctrl_if.sv
// Request-channel bundle between the rasterizer memory clients and the SRAM controller.
// Per-channel fields are packed side by side, channel i in slice i of each vector.
interface sram_multiport_ctrl_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 20
);
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        we;
  logic [NUM_CH*ADDR_W-1:0] addr;
  logic [NUM_CH*16-1:0]     wdata;
  logic [NUM_CH*2-1:0]      be;
  logic [NUM_CH-1:0]        gnt;
  logic [NUM_CH-1:0]        rd_valid;
  logic [15:0]              rd_data;
  logic                     busy;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rd_valid, rd_data, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rd_valid, rd_data, busy
  );
endinterface

// File: rtl/sram_multiport_ctrl.sv
// Round-robin multi-channel controller for an asynchronous 16-bit SRAM.
// Pins are registered from the current state, so they trail the state register by one clock.
module sram_multiport_ctrl #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              Clk_100,
  input  logic              reset_n,
  sram_multiport_ctrl_if.slave bus,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [15:0]       Data
);

  localparam int unsigned PtrW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CntW = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StHold} state_e;

  state_e              state_q;
  logic [PtrW-1:0]     rr_ptr_q;
  logic [PtrW-1:0]     owner_q;
  logic [CntW-1:0]     cnt_q;
  logic                op_we_q;
  logic [ADDR_W-1:0]   op_addr_q;
  logic [15:0]         op_wdata_q;
  logic [1:0]          op_be_q;
  logic [NUM_CH-1:0]   gnt_q;
  logic [NUM_CH-1:0]   rd_valid_q;
  logic [15:0]         rd_data_q;
  logic                drive_q;

  logic                found;
  logic [PtrW-1:0]     winner;
  logic [PtrW-1:0]     next_ptr;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [15:0]         win_wdata;
  logic [1:0]          win_be;
  int unsigned         idx;

  // First requester at or after rr_ptr, scanning with wrap-around.
  always_comb begin
    found     = 1'b0;
    winner    = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_be    = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_CH;
      if (!found && bus.req[idx]) begin
        found     = 1'b1;
        winner    = PtrW'(idx);
        win_we    = bus.we[idx];
        win_addr  = bus.addr[idx*ADDR_W +: ADDR_W];
        win_wdata = bus.wdata[idx*16 +: 16];
        win_be    = bus.be[idx*2 +: 2];
      end
    end
    next_ptr = (int'(winner) == NUM_CH - 1) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge Clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      op_we_q    <= 1'b0;
      op_addr_q  <= '0;
      op_wdata_q <= '0;
      op_be_q    <= '0;
      gnt_q      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      drive_q    <= 1'b0;
      CE         <= 1'b1;
      UB         <= 1'b1;
      LB         <= 1'b1;
      OE         <= 1'b1;
      WE         <= 1'b1;
      ADDR       <= '0;
    end else begin
      gnt_q      <= '0;
      rd_valid_q <= '0;
      unique case (state_q)
        StIdle: begin
          CE      <= 1'b1;
          UB      <= 1'b1;
          LB      <= 1'b1;
          OE      <= 1'b1;
          WE      <= 1'b1;
          drive_q <= 1'b0;
          if (found) begin
            gnt_q[winner] <= 1'b1;
            owner_q       <= winner;
            op_we_q       <= win_we;
            op_addr_q     <= win_addr;
            op_wdata_q    <= win_wdata;
            op_be_q       <= win_be;
            rr_ptr_q      <= next_ptr;
            state_q       <= StSetup;
          end
        end
        StSetup: begin
          CE      <= 1'b0;
          ADDR    <= op_addr_q;
          UB      <= ~op_be_q[1];
          LB      <= ~op_be_q[0];
          OE      <= 1'b1;
          WE      <= 1'b1;
          drive_q <= op_we_q;
          cnt_q   <= CntW'(WAIT_CYCLES - 1);
          state_q <= StAccess;
        end
        StAccess: begin
          WE <= ~op_we_q;
          OE <= op_we_q;
          if (cnt_q == '0) begin
            state_q <= StHold;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StHold: begin
          // This edge closes the last ACCESS cycle on the pins: sample the read data here.
          WE <= 1'b1;
          OE <= 1'b1;
          if (!op_we_q) begin
            rd_data_q           <= Data;
            rd_valid_q[owner_q] <= 1'b1;
          end
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign Data         = drive_q ? op_wdata_q : 16'hzzzz;
  assign bus.gnt      = gnt_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_sram_multiport_ctrl.sv
// Randomized bench for sram_multiport_ctrl with an SRAM pin model and a word-level
// reference memory plus round-robin pointer model.
module tb_sram_multiport_ctrl;
  localparam int unsigned NCH  = 4;
  localparam int unsigned AW   = 20;
  localparam int unsigned W    = 2;
  localparam int          LOGN = 8192;

  logic          Clk_100 = 1'b0;
  logic          reset_n = 1'b0;
  logic          CE, UB, LB, OE, WE;
  logic [AW-1:0] ADDR;
  wire  [15:0]   Data;

  always #5 Clk_100 = ~Clk_100;

  sram_multiport_ctrl_if #(.NUM_CH(NCH), .ADDR_W(AW)) bus ();

  sram_multiport_ctrl #(.NUM_CH(NCH), .ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .Clk_100 (Clk_100),
    .reset_n (reset_n),
    .bus     (bus),
    .CE      (CE),
    .UB      (UB),
    .LB      (LB),
    .OE      (OE),
    .WE      (WE),
    .ADDR    (ADDR),
    .Data    (Data)
  );

  // SRAM pin model (environment) and reference contents (expectation).
  logic [15:0] sram    [256];
  logic [15:0] ref_mem [256];
  logic        load = 1'b1;

  assign Data = (!CE && !OE && WE) ? sram[ADDR[7:0]] : 16'hzzzz;

  always @(posedge Clk_100) begin
    if (load) begin
      for (int i = 0; i < 256; i++) sram[i] <= ref_mem[i];
    end else if (!CE && !WE) begin
      if (!UB) sram[ADDR[7:0]][15:8] <= Data[15:8];
      if (!LB) sram[ADDR[7:0]][7:0]  <= Data[7:0];
    end
  end

  // Per-cycle pin log, sampled 1 ns after each rising edge.
  logic [NCH-1:0] log_gnt  [LOGN];
  logic [4:0]     log_ctl  [LOGN];
  logic [15:0]    log_data [LOGN];
  int             cyc        = 0;
  int             contention = 0;
  int             onehot_err = 0;

  always @(posedge Clk_100) begin
    #1;
    if (cyc < LOGN) begin
      log_gnt[cyc]  = bus.gnt;
      log_ctl[cyc]  = {CE, UB, LB, OE, WE};
      log_data[cyc] = Data;
    end
    if (!OE && !WE) contention++;
    if ($countones(bus.gnt) > 1 || $countones(bus.rd_valid) > 1) onehot_err++;
    cyc++;
  end

  int n_vec = 0;
  int n_err = 0;
  int ref_ptr = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk_100);
    #2;
  endtask

  function automatic int now_cyc();
    return cyc - 1;
  endfunction

  function automatic int rr_pick(input int p, input logic [NCH-1:0] m);
    for (int k = 0; k < NCH; k++) begin
      if (m[(p + k) % NCH]) return (p + k) % NCH;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_ch(input int ch, input logic w, input logic [AW-1:0] a,
                        input logic [15:0] d, input logic [1:0] b);
    bus.we[ch]             = w;
    bus.addr[ch*AW +: AW]  = a;
    bus.wdata[ch*16 +: 16] = d;
    bus.be[ch*2 +: 2]      = b;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.busy && k < 64) begin
      tick();
      k++;
    end
    check_eq("idle_reached", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic do_op(input int ch, input logic w, input logic [AW-1:0] a,
                       input logic [15:0] d, input logic [1:0] b,
                       output int tg, output int tv, output logic [15:0] rd);
    int k;
    logic seen;
    set_ch(ch, w, a, d, b);
    bus.req[ch] = 1'b1;
    seen = 1'b0;
    k = 0;
    tg = -1;
    tv = -1;
    rd = '0;
    while (!seen && k < 64) begin
      tick();
      if (bus.gnt != '0) seen = 1'b1;
      k++;
    end
    bus.req[ch] = 1'b0;
    check_eq("gnt_seen", {31'd0, seen}, 32'd1);
    check_eq("gnt_chan", {28'd0, bus.gnt}, 32'd1 << ch);
    tg = now_cyc();
    ref_ptr = (ch + 1) % NCH;
    if (w) begin
      if (b[1]) ref_mem[a[7:0]][15:8] = d[15:8];
      if (b[0]) ref_mem[a[7:0]][7:0]  = d[7:0];
    end else begin
      seen = 1'b0;
      k = 0;
      while (!seen && k < 32) begin
        tick();
        if (bus.rd_valid != '0) seen = 1'b1;
        k++;
      end
      check_eq("rdv_seen", {31'd0, seen}, 32'd1);
      check_eq("rdv_chan", {28'd0, bus.rd_valid}, 32'd1 << ch);
      tv = now_cyc();
      rd = bus.rd_data;
    end
  endtask

  // Bit k of each mask = control asserted (low) at cycle tg+k, for k = 0..W+3.
  task automatic pin_masks(input int tg, output int we_m, output int oe_m, output int ce_m);
    we_m = 0;
    oe_m = 0;
    ce_m = 0;
    for (int k = 0; k <= W + 3; k++) begin
      if (!log_ctl[tg+k][0]) we_m |= (1 << k);
      if (!log_ctl[tg+k][1]) oe_m |= (1 << k);
      if (!log_ctl[tg+k][4]) ce_m |= (1 << k);
    end
  endtask

  // Raise req on every channel in m; record n grants against the round-robin model.
  task automatic rr_run(input logic [NCH-1:0] m, input int n, input logic drop_on_gnt);
    int got = 0;
    int prev = -1;
    int k = 0;
    int g;
    int e;
    bus.req = m;
    while (got < n && k < 200) begin
      tick();
      if (bus.gnt != '0) begin
        g = oh_idx(bus.gnt);
        e = rr_pick(ref_ptr, bus.req);
        check_eq("rr_order", g, e);
        if (prev >= 0) check_eq("rr_period", now_cyc() - prev, W + 3);
        prev = now_cyc();
        ref_ptr = (g + 1) % NCH;
        if (drop_on_gnt && g >= 0) bus.req[g] = 1'b0;
        got++;
      end
      k++;
    end
    bus.req = '0;
    check_eq("rr_count", got, n);
    wait_idle();
  endtask

  task automatic reset_mid(input logic w, input int ch, input logic [AW-1:0] a);
    int k = 0;
    int rdv = 0;
    logic seen = 1'b0;
    set_ch(ch, w, a, 16'h5555, 2'b11);
    bus.req[ch] = 1'b1;
    while (!seen && k < 64) begin
      tick();
      if (bus.gnt != '0) seen = 1'b1;
      k++;
    end
    bus.req[ch] = 1'b0;
    check_eq("rst_gnt_seen", {31'd0, seen}, 32'd1);
    tick();
    tick();
    check_eq("pre_rst_access", {31'd0, (w ? WE : OE)}, 32'd0);
    #1 reset_n = 1'b0;
    #1;
    check_eq("rst_ctl", {27'd0, CE, UB, LB, OE, WE}, 32'h1f);
    check_eq("rst_gnt_rdv", {24'd0, bus.gnt, bus.rd_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_rd_data", {16'd0, bus.rd_data}, 32'd0);
    tick();
    reset_n = 1'b1;
    ref_ptr = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rd_valid != '0 || bus.busy) rdv++;
    end
    check_eq("post_rst_quiet", rdv, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tg, tv, wm, om, cm, nd;
    logic [15:0] rd, d;
    logic [1:0] b;
    int a;

    for (int i = 0; i < 256; i++) ref_mem[i] = 16'($urandom);
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.be    = '0;
    repeat (3) tick();

    check_eq("reset_ctl", {27'd0, CE, UB, LB, OE, WE}, 32'h1f);
    check_eq("reset_addr", {12'd0, ADDR}, 32'd0);
    check_eq("reset_gnt_rdv", {24'd0, bus.gnt, bus.rd_valid}, 32'd0);
    check_eq("reset_rd_data", {16'd0, bus.rd_data}, 32'd0);
    check_eq("reset_busy", {31'd0, bus.busy}, 32'd0);
    load = 1'b0;
    reset_n = 1'b1;
    repeat (2) tick();

    // Single write then read on ch0.
    do_op(0, 1'b1, 20'd2, 16'h000A, 2'b11, tg, tv, rd);
    wait_idle();
    repeat (2) tick();
    pin_masks(tg, wm, om, cm);
    check_eq("wr_we_mask", wm, ((1 << W) - 1) << 2);
    check_eq("wr_oe_mask", om, 0);
    check_eq("wr_ce_mask", cm, ((1 << (W + 2)) - 1) << 1);
    nd = 0;
    for (int k = 1; k <= W + 2; k++) if (log_data[tg+k] == 16'h000A) nd++;
    check_eq("wr_data_cycles", nd, W + 2);

    do_op(0, 1'b0, 20'd2, 16'h0000, 2'b11, tg, tv, rd);
    check_eq("rd_latency", tv - tg, W + 2);
    check_eq("rd_data_000A", {16'd0, rd}, 32'h000A);
    wait_idle();
    repeat (2) tick();
    pin_masks(tg, wm, om, cm);
    check_eq("rd_oe_mask", om, ((1 << W) - 1) << 2);
    check_eq("rd_we_mask", wm, 0);

    // Byte enables.
    do_op(1, 1'b1, 20'd5, 16'h1234, 2'b11, tg, tv, rd);
    do_op(1, 1'b1, 20'd5, 16'hABCD, 2'b01, tg, tv, rd);
    wait_idle();
    tick();
    check_eq("be01_ub_lb", {30'd0, log_ctl[tg+1][3:2]}, 32'h2);
    do_op(2, 1'b0, 20'd5, 16'h0000, 2'b11, tg, tv, rd);
    check_eq("be01_readback", {16'd0, rd}, 32'h12CD);
    do_op(2, 1'b1, 20'd5, 16'hFFFF, 2'b00, tg, tv, rd);
    wait_idle();
    tick();
    check_eq("be00_ub_lb", {30'd0, log_ctl[tg+1][3:2]}, 32'h3);
    do_op(3, 1'b0, 20'd5, 16'h0000, 2'b00, tg, tv, rd);
    check_eq("be00_readback", {16'd0, rd}, {16'd0, ref_mem[5]});
    wait_idle();

    // Round-robin: all channels requesting, then ch2/ch3 with the pointer at 3.
    for (int c = 0; c < NCH; c++) set_ch(c, 1'b0, AW'(40 + c), 16'h0, 2'b11);
    check_eq("rr_start_ptr", ref_ptr, 0);
    rr_run({NCH{1'b1}}, 6, 1'b0);
    do_op(2, 1'b0, 20'd41, 16'h0, 2'b11, tg, tv, rd);
    wait_idle();
    check_eq("rr_ptr_3", ref_ptr, 3);
    rr_run(4'b1100, 2, 1'b1);

    // Alternating write/read on random channels, addresses 3..18.
    for (int i = 0; i < 16; i++) begin
      d = 16'($urandom);
      b = 2'($urandom_range(0, 3));
      do_op(int'($urandom_range(0, NCH - 1)), 1'b1, AW'(3 + i), d, b, tg, tv, rd);
      do_op(int'($urandom_range(0, NCH - 1)), 1'b0, AW'(3 + i), 16'h0, 2'b11, tg, tv, rd);
      check_eq("alt_readback", {16'd0, rd}, {16'd0, ref_mem[3 + i]});
      check_eq("alt_latency", tv - tg, W + 2);
    end
    for (int i = 0; i < 4; i++) begin
      a = 3 + int'($urandom_range(0, 15));
      do_op(int'($urandom_range(0, NCH - 1)), 1'b0, AW'(a), 16'h0, 2'b11, tg, tv, rd);
      check_eq("rand_readback", {16'd0, rd}, {16'd0, ref_mem[a]});
    end
    wait_idle();

    // Reset in the middle of a write and of a read, then recover.
    reset_mid(1'b1, 1, 20'd60);
    reset_mid(1'b0, 0, 20'd3);
    do_op(1, 1'b0, 20'd4, 16'h0, 2'b11, tg, tv, rd);
    check_eq("post_rst_read", {16'd0, rd}, {16'd0, ref_mem[4]});
    wait_idle();

    check_eq("bus_contention", contention, 0);
    check_eq("onehot_pulses", onehot_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
